// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage of the pipelined MIPS core.
// Adds WAIT_CYCLES of access latency, stalls the pipeline meanwhile and returns load data on completion.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        read_valid,
   output logic        mem_stall,
   output logic        misaligned,
   output logic        proto_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [31:0]      mem [DEPTH_WORDS];
   logic             req;
   logic [IDX_W-1:0] idx;
   logic             accept;
   logic             mem_we;
   logic [IDX_W-1:0] we_idx;
   logic [31:0]      we_data;
   logic             unused_addr_bits;

   assign req = mem_read | mem_write;
   assign idx = address[2 +: IDX_W];
   // Upper address bits are dropped so accesses wrap modulo the array size.
   assign unused_addr_bits = ^address[31:2+IDX_W];

   // NOTE: the storage array has no reset; only control state is cleared, so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (mem_we) mem[we_idx] <= we_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misaligned <= 1'b0;
         proto_err  <= 1'b0;
      end else if (accept) begin
         if (address[1:0] != 2'b00) misaligned <= 1'b1;
         if (mem_read && mem_write) proto_err <= 1'b1;
      end
   end

   generate
      if (WAIT_CYCLES == 0) begin : g_single
         assign accept     = req;
         assign mem_we     = rst & mem_write;
         assign we_idx     = idx;
         assign we_data    = write_data;
         assign read_valid = rst & mem_read & ~mem_write;
         assign read_data  = read_valid ? mem[idx] : 32'h0;
         assign mem_stall  = 1'b0;
      end else begin : g_multi
         localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
         localparam logic [0:0] ST_IDLE = 1'b0;
         localparam logic [0:0] ST_BUSY = 1'b1;

         logic [0:0]       state;
         logic [CNT_W-1:0] cnt;
         logic [IDX_W-1:0] lat_idx;
         logic [31:0]      lat_data;
         logic             lat_wr;
         logic             lat_rd;
         logic             done;

         // Completion needs req still held; a dropped req means the pipeline flushed the access.
         assign done       = (state == ST_BUSY) && (cnt == CNT_LAST) && req;
         assign accept     = (state == ST_IDLE) && req;
         assign mem_stall  = rst & (accept | ((state == ST_BUSY) && (cnt != CNT_LAST)));
         assign read_valid = rst & done & lat_rd;
         assign read_data  = read_valid ? mem[lat_idx] : 32'h0;
         assign mem_we     = rst & done & lat_wr;
         assign we_idx     = lat_idx;
         assign we_data    = lat_data;

         // NOTE: every register here uses non-blocking assignment so all state updates see pre-edge values.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state    <= ST_IDLE;
               cnt      <= '0;
               lat_idx  <= '0;
               lat_data <= 32'h0;
               lat_wr   <= 1'b0;
               lat_rd   <= 1'b0;
            end else if (state == ST_IDLE) begin
               if (req) begin
                  lat_idx  <= idx;
                  lat_data <= write_data;
                  lat_wr   <= mem_write;
                  lat_rd   <= mem_read & ~mem_write;
                  cnt      <= CNT_W'(1);
                  state    <= ST_BUSY;
               end
            end else begin
               if (!req || cnt == CNT_LAST) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances cover WAIT_CYCLES = 2, 0 and 3.
module tb_data_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst2, rd2, wr2, rv2, st2, mis2, pe2;
   logic [31:0] a2, d2, rdata2;
   logic        rst0, rd0, wr0, rv0, st0, mis0, pe0;
   logic [31:0] a0, d0, rdata0;
   logic        rst3, rd3, wr3, rv3, st3, mis3, pe3;
   logic [31:0] a3, d3, rdata3;

   int n_checks = 0;
   int n_err    = 0;

   logic [31:0] q2[$];
   logic [31:0] q0[$];
   logic [31:0] q3[$];

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u2 (
      .clk(clk), .rst(rst2), .mem_read(rd2), .mem_write(wr2), .address(a2), .write_data(d2),
      .read_data(rdata2), .read_valid(rv2), .mem_stall(st2), .misaligned(mis2), .proto_err(pe2));

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u0 (
      .clk(clk), .rst(rst0), .mem_read(rd0), .mem_write(wr0), .address(a0), .write_data(d0),
      .read_data(rdata0), .read_valid(rv0), .mem_stall(st0), .misaligned(mis0), .proto_err(pe0));

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u3 (
      .clk(clk), .rst(rst3), .mem_read(rd3), .mem_write(wr3), .address(a3), .write_data(d3),
      .read_data(rdata3), .read_valid(rv3), .mem_stall(st3), .misaligned(mis3), .proto_err(pe3));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitors: every presented load must match the oldest expected value; idle data must be zero.
   always @(negedge clk) begin
      if (rv2) begin
         if (q2.size() == 0) check("u2 unexpected read_valid", {31'b0, rv2}, 32'h0);
         else check("u2 read_data", rdata2, q2.pop_front());
      end else check("u2 idle read_data", rdata2, 32'h0);
      if (rv0) begin
         if (q0.size() == 0) check("u0 unexpected read_valid", {31'b0, rv0}, 32'h0);
         else check("u0 read_data", rdata0, q0.pop_front());
      end else check("u0 idle read_data", rdata0, 32'h0);
      if (rv3) begin
         if (q3.size() == 0) check("u3 unexpected read_valid", {31'b0, rv3}, 32'h0);
         else check("u3 read_data", rdata3, q3.pop_front());
      end else check("u3 idle read_data", rdata3, 32'h0);
   end

   task automatic do2(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input bit wiggle, input string nm);
      rd2 = rd; wr2 = wr; a2 = a; d2 = d;
      for (int c = 0; c <= 2; c++) begin
         @(negedge clk);
         check({nm, " stall"}, {31'b0, st2}, (c < 2) ? 32'h1 : 32'h0);
         if (c == 2) check({nm, " read_valid"}, {31'b0, rv2}, {31'b0, rd & ~wr});
         @(posedge clk); #1;
         if (wiggle && c == 0) begin
            a2 = a ^ 32'h4;
            d2 = ~d;
         end
      end
      rd2 = 1'b0; wr2 = 1'b0;
   endtask

   task automatic do3(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input string nm);
      rd3 = rd; wr3 = wr; a3 = a; d3 = d;
      for (int c = 0; c <= 3; c++) begin
         @(negedge clk);
         check({nm, " stall"}, {31'b0, st3}, (c < 3) ? 32'h1 : 32'h0);
         @(posedge clk); #1;
      end
      rd3 = 1'b0; wr3 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst2 = 1'b0; rd2 = 1'b0; wr2 = 1'b0; a2 = 32'h0; d2 = 32'h0;
      rst0 = 1'b0; rd0 = 1'b0; wr0 = 1'b0; a0 = 32'h0; d0 = 32'h0;
      rst3 = 1'b0; rd3 = 1'b0; wr3 = 1'b0; a3 = 32'h0; d3 = 32'h0;

      @(negedge clk);
      check("reset stall", {31'b0, st2}, 32'h0);
      check("reset read_valid", {31'b0, rv2}, 32'h0);
      check("reset misaligned", {31'b0, mis2}, 32'h0);
      check("reset proto_err", {31'b0, pe2}, 32'h0);
      @(posedge clk); #1;
      rst2 = 1'b1; rst0 = 1'b1; rst3 = 1'b1;

      // WAIT_CYCLES = 2
      do2(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "w10");
      q2.push_back(32'hDEADBEEF);
      do2(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "r10");
      do2(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b0, "w400");
      q2.push_back(32'hA5A5A5A5);
      do2(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "r0 wrap");
      check("misaligned before", {31'b0, mis2}, 32'h0);
      q2.push_back(32'hDEADBEEF);
      do2(1'b1, 1'b0, 32'h13, 32'h0, 1'b0, "r13");
      check("misaligned after", {31'b0, mis2}, 32'h1);
      check("proto_err before", {31'b0, pe2}, 32'h0);
      do2(1'b1, 1'b1, 32'h8, 32'h1, 1'b0, "rw8");
      check("proto_err after", {31'b0, pe2}, 32'h1);
      q2.push_back(32'h1);
      do2(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, "r8");
      do2(1'b0, 1'b1, 32'h24, 32'h33, 1'b0, "w24");
      do2(1'b0, 1'b1, 32'h20, 32'h11112222, 1'b1, "w20 wiggle");
      q2.push_back(32'h33);
      do2(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, "r24");
      q2.push_back(32'h11112222);
      do2(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, "r20");

      // WAIT_CYCLES = 0
      wr0 = 1'b1; a0 = 32'h4; d0 = 32'h0BADF00D;
      @(negedge clk); check("u0 write stall", {31'b0, st0}, 32'h0);
      @(posedge clk); #1;
      wr0 = 1'b0; rd0 = 1'b1; q0.push_back(32'h0BADF00D);
      @(negedge clk); check("u0 read stall", {31'b0, st0}, 32'h0);
      @(posedge clk); #1;
      rd0 = 1'b0; wr0 = 1'b1; a0 = 32'h8; d0 = 32'h77;
      @(negedge clk);
      @(posedge clk); #1;
      wr0 = 1'b0; rd0 = 1'b1; a0 = 32'h4; q0.push_back(32'h0BADF00D);
      @(negedge clk);
      @(posedge clk); #1;
      rd0 = 1'b1; a0 = 32'h8; q0.push_back(32'h77);
      @(negedge clk);
      @(posedge clk); #1;
      rd0 = 1'b0;

      // WAIT_CYCLES = 3: flush
      do3(1'b0, 1'b1, 32'h40, 32'hCAFE0001, "w40");
      wr3 = 1'b1; a3 = 32'h40; d3 = 32'hBAD00BAD;
      @(negedge clk); check("flush c0 stall", {31'b0, st3}, 32'h1);
      @(posedge clk); #1;
      wr3 = 1'b0;
      @(negedge clk); check("flush c1 stall", {31'b0, st3}, 32'h1);
      @(posedge clk); #1;
      @(negedge clk); check("flush c2 stall", {31'b0, st3}, 32'h0);
      @(posedge clk); #1;
      q3.push_back(32'hCAFE0001);
      do3(1'b1, 1'b0, 32'h41, 32'h0, "r41");
      check("u3 misaligned", {31'b0, mis3}, 32'h1);

      // WAIT_CYCLES = 3: reset mid-write
      wr3 = 1'b1; a3 = 32'h40; d3 = 32'h5555AAAA;
      @(negedge clk); check("rst c0 stall", {31'b0, st3}, 32'h1);
      @(posedge clk); #1;
      check("rst c1 stall before", {31'b0, st3}, 32'h1);
      rst3 = 1'b0; #1;
      check("rst stall", {31'b0, st3}, 32'h0);
      check("rst read_valid", {31'b0, rv3}, 32'h0);
      check("rst read_data", rdata3, 32'h0);
      check("rst misaligned", {31'b0, mis3}, 32'h0);
      wr3 = 1'b0;
      @(posedge clk); #1;
      rst3 = 1'b1;
      q3.push_back(32'hCAFE0001);
      do3(1'b1, 1'b0, 32'h40, 32'h0, "r40 after rst");

      @(negedge clk);
      check("u2 queue drained", q2.size(), 32'h0);
      check("u0 queue drained", q0.size(), 32'h0);
      check("u3 queue drained", q3.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
